// File: rtl/psum_sched_if.sv
// Handshake/config bundle between the tile controller, the computing core and writeback.
// Latency: none, plain wires grouped for port hygiene.
// Backpressure: carries mac_ready (core) and out_ready (writeback); no storage.
//
// Ports (master = controller side, slave = psum_sched):
//   start/kernel/c_tile_in/abort  job request and configuration
//   mac_ready/psum_finish         core and accumulator status
//   out_ready                     writeback accept
//   core_valid/kernel_o/c_tile_o  beat strobe and latched job configuration
//   busy/out_valid/done/error     job status
//   beat_cnt                      beats issued in the current job
interface psum_sched_if;
    logic        start;
    logic [2:0]  kernel;
    logic [9:0]  c_tile_in;
    logic        abort;
    logic        mac_ready;
    logic        psum_finish;
    logic        out_ready;
    logic        core_valid;
    logic [2:0]  kernel_o;
    logic [9:0]  c_tile_o;
    logic        busy;
    logic        out_valid;
    logic        done;
    logic        error;
    logic [11:0] beat_cnt;

    modport master (
        output start, kernel, c_tile_in, abort, mac_ready, psum_finish, out_ready,
        input  core_valid, kernel_o, c_tile_o, busy, out_valid, done, error, beat_cnt
    );

    modport slave (
        input  start, kernel, c_tile_in, abort, mac_ready, psum_finish, out_ready,
        output core_valid, kernel_o, c_tile_o, busy, out_valid, done, error, beat_cnt
    );
endinterface

// File: rtl/psum_sched.sv
// Partial-sum scheduler: issues K*K*G core beats per tile, waits for the accumulator, hands off the tile.
// Latency: accepted start -> first beat next cycle; last beat -> DRAIN next cycle; OUT lasts until out_ready.
// Backpressure: mac_ready low stalls issue with all counters held; out_ready low holds out_valid in OUT.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  psum_sched_if.slave (config in, core/writeback handshakes, status out)
module psum_sched #(
    parameter int C_NUMBER_MAX = 64,
    parameter int DRAIN_MAX    = 15
) (
    input  logic         clk,
    input  logic         rst,
    psum_sched_if.slave  bus
);

    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t        state, state_nxt;

    logic [2:0]    kernel_q;
    logic [9:0]    c_tile_q;
    logic [11:0]   beat_q;
    logic [2:0]    add_cnt;
    logic [5:0]    c_cnt;
    logic [2:0]    k_cnt;
    logic          fin_flag;
    logic [DW-1:0] drain_cnt;

    logic [5:0]    g_in;
    logic [5:0]    g_lat;
    logic          cfg_ok;
    logic          accept;
    logic          beat;
    logic          add_wrap;
    logic          c_wrap;
    logic          last_beat;
    logic          drain_timeout;
    logic          err_c;
    logic          done_c;

    // G is the 16-channel group count; it can never exceed 63 from a 10-bit field,
    // so C_NUMBER_MAX only narrows what is legal.
    assign g_in   = bus.c_tile_in[9:4];
    assign g_lat  = c_tile_q[9:4];
    assign cfg_ok = (bus.kernel != 3'd0) && (g_in != 6'd0) &&
                    ({26'd0, g_in} <= 32'(C_NUMBER_MAX));

    assign add_wrap  = (add_cnt == kernel_q);
    assign c_wrap    = (c_cnt == g_lat - 6'd1);
    assign last_beat = add_wrap && c_wrap && (k_cnt == kernel_q);

    assign drain_timeout = (drain_cnt == DW'(DRAIN_MAX - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        beat      = 1'b0;
        err_c     = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                // abort is meaningless in IDLE, so a coincident start simply proceeds
                if (bus.start) begin
                    if (cfg_ok) begin
                        accept    = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.mac_ready) begin
                    beat = 1'b1;
                    if (last_beat) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (fin_flag || bus.psum_finish) begin
                    state_nxt = OUT;
                end else if (drain_timeout) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bus.out_ready) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kernel_q  <= 3'd0;
            c_tile_q  <= 10'd0;
            beat_q    <= 12'd0;
            add_cnt   <= 3'd0;
            c_cnt     <= 6'd0;
            k_cnt     <= 3'd0;
            fin_flag  <= 1'b0;
            drain_cnt <= '0;
        end else if (accept) begin
            kernel_q  <= bus.kernel;
            c_tile_q  <= bus.c_tile_in;
            beat_q    <= 12'd0;
            add_cnt   <= 3'd1;
            c_cnt     <= 6'd0;
            k_cnt     <= 3'd1;
            fin_flag  <= 1'b0;
            drain_cnt <= '0;
        end else begin
            // innermost add_cnt, then channel group, then kernel row
            if (beat) begin
                beat_q <= beat_q + 12'd1;
                if (add_wrap) begin
                    add_cnt <= 3'd1;
                    if (c_wrap) begin
                        c_cnt <= 6'd0;
                        k_cnt <= (k_cnt == kernel_q) ? 3'd1 : k_cnt + 3'd1;
                    end else begin
                        c_cnt <= c_cnt + 6'd1;
                    end
                end else begin
                    add_cnt <= add_cnt + 3'd1;
                end
            end
            // the accumulator may finish before the last beat leaves ISSUE
            if (state == ISSUE && bus.psum_finish) begin
                fin_flag <= 1'b1;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    assign bus.core_valid = (state == ISSUE) && bus.mac_ready && !bus.abort;
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == OUT);
    assign bus.done       = done_c;
    // the bad-start term is combinational from start; keep it quiet while reset is held
    assign bus.error      = err_c && rst;
    assign bus.kernel_o   = kernel_q;
    assign bus.c_tile_o   = c_tile_q;
    assign bus.beat_cnt   = beat_q;

endmodule

// File: tb/tb_psum_sched.sv
// Directed bench for psum_sched: reset, nominal job, stalls, bad config, drain timeout,
// held writeback, abort and mid-job reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_psum_sched;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    psum_sched_if bus();

    psum_sched #(.C_NUMBER_MAX(64), .DRAIN_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bus.busy, bus.core_valid, bus.out_valid, bus.done, bus.error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.busy, bus.core_valid, bus.out_valid, bus.done, bus.error});
        end
        checks++;
        if (bus.beat_cnt !== 12'd0 || bus.kernel_o !== 3'd0 || bus.c_tile_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_regs got beat=%0d k=%0d c=%0d want 0 0 0",
                     bus.beat_cnt, bus.kernel_o, bus.c_tile_o);
        end
    endtask

    // K=3, G=2: 18 beats, psum_finish in the 4th DRAIN cycle, immediate out_ready
    task automatic test_basic;
        int bad;
        bus.kernel = 3'd3; bus.c_tile_in = 10'd32; bus.mac_ready = 1'b1;
        bus.out_ready = 1'b1; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.core_valid !== 1'b0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept got busy=%b cv=%b err=%b want 0 0 0",
                     bus.busy, bus.core_valid, bus.error);
        end
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            #1;
            if (bus.core_valid !== 1'b1 || bus.beat_cnt !== 12'(i)) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_beats got %0d bad beat cycles want 0", bad);
        end
        bad = 0;
        for (int d = 1; d <= 4; d++) begin
            bus.psum_finish = (d == 4);
            #1;
            if (bus.core_valid !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) bad++;
            if (d == 1) begin
                checks++;
                if (bus.beat_cnt !== 12'd18 || bus.kernel_o !== 3'd3 || bus.c_tile_o !== 10'd32) begin
                    errors++;
                    $display("FAIL basic_drain_regs got beat=%0d k=%0d c=%0d want 18 3 32",
                             bus.beat_cnt, bus.kernel_o, bus.c_tile_o);
                end
            end
            tick();
        end
        bus.psum_finish = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_drain got %0d bad drain cycles want 0", bad);
        end
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL basic_out got ov=%b done=%b want 1 1", bus.out_valid, bus.done);
        end
        tick();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle got busy=%b ov=%b done=%b want 0 0 0",
                     bus.busy, bus.out_valid, bus.done);
        end
        tick();
    endtask

    // K=1, G=1 with mac_ready low for two cycles before the single beat
    task automatic test_mac_toggle;
        logic mr [3];
        int   bad;
        mr[0] = 1'b0; mr[1] = 1'b0; mr[2] = 1'b1;
        bus.kernel = 3'd1; bus.c_tile_in = 10'd16; bus.mac_ready = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            bus.mac_ready = mr[i];
            #1;
            if (bus.core_valid !== mr[i] || bus.beat_cnt !== 12'd0 || bus.busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mac_toggle_issue got %0d bad cycles want 0", bad);
        end
        bus.mac_ready = 1'b1;
        bus.psum_finish = 1'b1;
        #1;
        checks++;
        if (bus.core_valid !== 1'b0 || bus.beat_cnt !== 12'd1) begin
            errors++;
            $display("FAIL mac_toggle_drain got cv=%b beat=%0d want 0 1", bus.core_valid, bus.beat_cnt);
        end
        tick();
        bus.psum_finish = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL mac_toggle_done got %b want 1", bus.done);
        end
        tick();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.beat_cnt !== 12'd1) begin
            errors++;
            $display("FAIL mac_toggle_end got busy=%b beat=%0d want 0 1", bus.busy, bus.beat_cnt);
        end
        tick();
    endtask

    task automatic test_bad_cfg;
        bus.kernel = 3'd0; bus.c_tile_in = 10'd32; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.core_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_k0 got err=%b busy=%b cv=%b want 1 0 0",
                     bus.error, bus.busy, bus.core_valid);
        end
        tick();
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.error !== 1'b0 || bus.kernel_o !== 3'd1 || bus.c_tile_o !== 10'd16) begin
            errors++;
            $display("FAIL bad_k0_after got busy=%b err=%b k=%0d c=%0d want 0 0 1 16",
                     bus.busy, bus.error, bus.kernel_o, bus.c_tile_o);
        end
        tick();
        bus.kernel = 3'd3; bus.c_tile_in = 10'd8; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_g0 got err=%b busy=%b want 1 0", bus.error, bus.busy);
        end
        tick();
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.core_valid !== 1'b0 || bus.c_tile_o !== 10'd16) begin
            errors++;
            $display("FAIL bad_g0_after got busy=%b cv=%b c=%0d want 0 0 16",
                     bus.busy, bus.core_valid, bus.c_tile_o);
        end
        tick();
    endtask

    // K=2, G=1, no psum_finish: 4 beats, 15 DRAIN cycles, error in the last one
    task automatic test_timeout;
        int bad;
        bus.kernel = 3'd2; bus.c_tile_in = 10'd16; bus.mac_ready = 1'b1;
        bus.psum_finish = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.core_valid !== 1'b1) bad++;
            tick();
        end
        for (int d = 1; d <= 14; d++) begin
            #1;
            if (bus.error !== 1'b0 || bus.busy !== 1'b1 || bus.core_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_run got %0d bad cycles want 0", bad);
        end
        #1;
        checks++;
        if (bus.error !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err got err=%b busy=%b want 1 1", bus.error, bus.busy);
        end
        tick();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.error !== 1'b0 || bus.beat_cnt !== 12'd4) begin
            errors++;
            $display("FAIL timeout_idle got busy=%b err=%b beat=%0d want 0 0 4",
                     bus.busy, bus.error, bus.beat_cnt);
        end
        tick();
    endtask

    // K=3, G=4: finish arrives early during ISSUE, out_ready low for 10 OUT cycles
    task automatic test_out_hold;
        int bad;
        bus.kernel = 3'd3; bus.c_tile_in = 10'd64; bus.mac_ready = 1'b1;
        bus.out_ready = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 36; i++) begin
            bus.psum_finish = (i == 10);
            #1;
            if (bus.core_valid !== 1'b1) bad++;
            tick();
        end
        bus.psum_finish = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_beats got %0d bad beat cycles want 0", bad);
        end
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.beat_cnt !== 12'd36) begin
            errors++;
            $display("FAIL hold_drain got busy=%b ov=%b beat=%0d want 1 0 36",
                     bus.busy, bus.out_valid, bus.beat_cnt);
        end
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 3);
            bus.kernel = 3'd1; bus.c_tile_in = 10'd16;
            #1;
            if (bus.out_valid !== 1'b1 || bus.done !== 1'b0) bad++;
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_out got %0d bad OUT cycles want 0", bad);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_done got done=%b ov=%b want 1 1", bus.done, bus.out_valid);
        end
        tick();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.kernel_o !== 3'd3 || bus.c_tile_o !== 10'd64) begin
            errors++;
            $display("FAIL hold_idle got busy=%b ov=%b k=%0d c=%0d want 0 0 3 64",
                     bus.busy, bus.out_valid, bus.kernel_o, bus.c_tile_o);
        end
        tick();
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_queue got busy=%b want 0", bus.busy);
        end
        tick();
    endtask

    // full K=3, G=2 job with finish in the first DRAIN cycle
    task automatic run_full_job(input logic abort_with_start, input string tag);
        int bad;
        bus.kernel = 3'd3; bus.c_tile_in = 10'd32; bus.mac_ready = 1'b1;
        bus.out_ready = 1'b1; bus.start = 1'b1; bus.abort = abort_with_start;
        #1;
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept got err=%b want 0", tag, bus.error);
        end
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            #1;
            if (bus.core_valid !== 1'b1 || bus.beat_cnt !== 12'(i)) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_beats got %0d bad beat cycles want 0", tag, bad);
        end
        bus.psum_finish = 1'b1;
        tick();
        bus.psum_finish = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got %b want 1", tag, bus.done);
        end
        tick();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.beat_cnt !== 12'd18) begin
            errors++;
            $display("FAIL %s_end got busy=%b beat=%0d want 0 18", tag, bus.busy, bus.beat_cnt);
        end
        tick();
    endtask

    task automatic test_abort;
        int bad;
        bus.kernel = 3'd3; bus.c_tile_in = 10'd32; bus.mac_ready = 1'b1;
        bus.out_ready = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.core_valid !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_pre got %0d bad beat cycles want 0", bad);
        end
        bus.abort = 1'b1;
        #1;
        checks++;
        if (bus.core_valid !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL abort_now got cv=%b done=%b err=%b want 0 0 0",
                     bus.core_valid, bus.done, bus.error);
        end
        tick();
        bus.abort = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.beat_cnt !== 12'd4 || bus.kernel_o !== 3'd3 || bus.c_tile_o !== 10'd32) begin
            errors++;
            $display("FAIL abort_idle got busy=%b beat=%0d k=%0d c=%0d want 0 4 3 32",
                     bus.busy, bus.beat_cnt, bus.kernel_o, bus.c_tile_o);
        end
        tick();
        // start and abort together in IDLE: start wins
        run_full_job(1'b1, "abort_restart");

        bus.kernel = 3'd2; bus.c_tile_in = 10'd16; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.core_valid, bus.out_valid, bus.done, bus.error} !== 5'b0) begin
            errors++;
            $display("FAIL rst_drain_flags got %b want 00000",
                     {bus.busy, bus.core_valid, bus.out_valid, bus.done, bus.error});
        end
        checks++;
        if (bus.beat_cnt !== 12'd0 || bus.kernel_o !== 3'd0 || bus.c_tile_o !== 10'd0) begin
            errors++;
            $display("FAIL rst_drain_regs got beat=%0d k=%0d c=%0d want 0 0 0",
                     bus.beat_cnt, bus.kernel_o, bus.c_tile_o);
        end
        rst = 1'b1;
        tick();
        run_full_job(1'b0, "after_rst");
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.kernel = 3'd0; bus.c_tile_in = 10'd0; bus.abort = 1'b0;
        bus.mac_ready = 1'b0; bus.psum_finish = 1'b0; bus.out_ready = 1'b0;
        #11;
        test_reset();
        tick();
        rst = 1'b1;
        tick();
        test_basic();
        test_mac_toggle();
        test_bad_cfg();
        test_timeout();
        test_out_hold();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psum_sched.md
PSUM_SCHED -- requirements
Module: psum_sched

Interface
REQ-001 Parameter: C_NUMBER_MAX, default 64, maximum channel groups per tile (c_tile_in>>4).
REQ-002 Parameter: DRAIN_MAX, default 15, maximum cycles to wait in DRAIN for psum_finish.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run one output tile.
REQ-006 kernel  input  3  kernel size K; sampled on an accepted start.
REQ-007 c_tile_in  input  10  input channel count; groups G = c_tile_in>>4; sampled on an accepted start.
REQ-008 abort  input  1  synchronous abort.
REQ-009 mac_ready  input  1  computing core can emit one column this cycle.
REQ-010 psum_finish  input  1  tile-complete pulse from the psum accumulator.
REQ-011 out_ready  input  1  writeback accepts the tile.
REQ-012 core_valid  output  1  drives the accumulator in_valid; one beat per high cycle.
REQ-013 kernel_o  output  3  latched K, held for the whole job.
REQ-014 c_tile_o  output  10  latched c_tile_in, held for the whole job.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 out_valid  output  1  tile result available to writeback.
REQ-017 done  output  1  one-cycle pulse on tile handoff.
REQ-018 error  output  1  one-cycle pulse on bad configuration or drain timeout.
REQ-019 beat_cnt  output  12  beats issued in the current job.

Function
REQ-020 The FSM shall have the states IDLE, ISSUE, DRAIN and OUT.
REQ-021 In IDLE, start shall be accepted only if K is at least 1 and G is between 1 and C_NUMBER_MAX.
- Accepted start: latch kernel and c_tile_in, clear the counters and the finish flag, and go to ISSUE on the next cycle.
REQ-022 In IDLE, a start with an illegal configuration shall pulse error for one cycle, leave the FSM in IDLE and leave the latched values unchanged.
REQ-023 core_valid shall equal (state==ISSUE && mac_ready && !abort), combinationally.
- core_valid shall be 0 in every other state.
REQ-024 Each core_valid cycle shall advance nested counters, innermost first:
- add_cnt counts 1..K, then wraps to 1;
- when add_cnt wraps, c_cnt advances, counting 0..G-1 and wrapping to 0;
- when c_cnt wraps, k_cnt advances, counting 1..K.
- beat_cnt shall increment by 1 on every beat.
REQ-025 When mac_ready is low, all counters shall hold and the FSM shall stay in ISSUE.
REQ-026 The last beat is the beat with add_cnt==K, c_cnt==G-1 and k_cnt==K; the FSM shall move from ISSUE to DRAIN in the cycle after it.
- Total beats per job = K*K*G.
REQ-027 A psum_finish pulse seen in ISSUE shall set a sticky finish flag.
- In DRAIN, a set flag or a psum_finish pulse shall move the FSM to OUT on the next cycle.
REQ-028 DRAIN shall count its cycles; if the count reaches DRAIN_MAX with no finish, the FSM shall pulse error and return to IDLE.
REQ-029 In OUT, out_valid shall be 1 and shall stay 1 until out_ready is sampled high.
- In that cycle: done pulses, and the FSM returns to IDLE on the next cycle with out_valid 0.
REQ-030 psum_finish seen in IDLE or OUT shall be ignored.
REQ-031 start seen while busy shall be ignored and shall not be queued.
REQ-032 abort in any state except IDLE shall return the FSM to IDLE on the next cycle.
- No done and no error pulse.
- beat_cnt holds its value; kernel_o and c_tile_o hold their values.
REQ-033 If abort and start arrive together in IDLE, start wins.

Reset
REQ-034 Asserting rst low shall immediately force:
- state IDLE; core_valid, busy, out_valid, done, error = 0;
- kernel_o, c_tile_o, beat_cnt, all internal counters and the finish flag = 0.
REQ-035 Reset mid-job shall discard the job; the first start after rst deasserts shall be handled as in IDLE.

Verification
REQ-036 K=3, c_tile_in=32 (G=2), mac_ready=1, psum_finish 4 cycles after the last beat, out_ready=1 -> exactly 18 consecutive core_valid cycles, beat_cnt=18, DRAIN for 4 cycles, out_valid 1 cycle, done 1 cycle, then IDLE.
REQ-037 K=1, c_tile_in=16, mac_ready toggling 1/0 -> exactly 1 beat; core_valid only in mac_ready-high cycles; counters hold while mac_ready is low.
REQ-038 start with kernel=0, and separately with c_tile_in=8 -> error pulse, busy stays 0, no core_valid.
REQ-039 K=2, G=1, psum_finish never arrives -> 4 beats, then error after 15 DRAIN cycles, then IDLE.
REQ-040 K=3, G=4, out_ready held 0 for 10 cycles -> out_valid held 10 cycles; a second start during OUT is ignored; done when out_ready rises.
REQ-041 abort at beat 5 of a K=3, G=2 job, and separately rst pulled low in DRAIN -> IDLE, core_valid 0 at once, no done; a new start runs a full 18-beat job.
